// File: rtl/ps2_codes_pkg.sv
// rtl/ps2_codes_pkg.sv - PS/2 Set-2 byte constants, sequencer state type and sequencing helpers
//
// Purpose : shared definitions for the ASCII -> PS/2 make/break sequencer.
// Contents: PS2_EXT / PS2_BRK / PS2_LSHIFT prefix bytes, state_t enum,
//           seq_next() (state after a byte handshake) and seq_byte()
//           (byte presented while in a given state).
// Config  : ASCII_PS2_GAP_EN adds the GAP state to state_t.
package ps2_codes_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;

    typedef enum logic [3:0] {
        IDLE,
        SH_MK,
        EX_MK,
        CD_MK,
        EX_BK,
        F0_BK,
        CD_BK,
        F0_SH,
        SH_BK
`ifdef ASCII_PS2_GAP_EN
        , GAP
`endif
    } state_t;

    // Byte-carrying state that follows s once its byte is taken.
    // From IDLE this yields the first state of the sequence.
    function automatic state_t seq_next(input state_t s, input logic sh, input logic ex);
        case (s)
            IDLE:    seq_next = ex ? EX_MK : (sh ? SH_MK : CD_MK);
            SH_MK:   seq_next = CD_MK;
            EX_MK:   seq_next = CD_MK;
            CD_MK:   seq_next = ex ? EX_BK : F0_BK;
            EX_BK:   seq_next = F0_BK;
            F0_BK:   seq_next = CD_BK;
            CD_BK:   seq_next = sh ? F0_SH : IDLE;
            F0_SH:   seq_next = SH_BK;
            default: seq_next = IDLE;
        endcase
    endfunction

    function automatic logic [7:0] seq_byte(input state_t s, input logic [7:0] code);
        case (s)
            SH_MK, SH_BK: seq_byte = PS2_LSHIFT;
            EX_MK, EX_BK: seq_byte = PS2_EXT;
            F0_BK, F0_SH: seq_byte = PS2_BRK;
            CD_MK, CD_BK: seq_byte = code;
            default:      seq_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ascii2ps2_lut.sv
// rtl/ascii2ps2_lut.sv - combinational ASCII/extended character to PS/2 Set-2 key code table
//
// Purpose: maps one character to the key's Set-2 code plus shift/extended flags.
// Ports  : ascii     in  8  character code
//          code      out 8  Set-2 key code (0 when no mapping)
//          shift_req out 1  key needs left shift held
//          ext_req   out 1  key uses the E0 extended prefix
//          hit       out 1  character has a mapping
module ascii2ps2_lut (
    input  logic [7:0] ascii,
    output logic [7:0] code,
    output logic       shift_req,
    output logic       ext_req,
    output logic       hit
);

    function automatic logic [7:0] letter_code(input logic [7:0] c);
        case (c)
            8'h61: letter_code = 8'h1C; 8'h62: letter_code = 8'h32; 8'h63: letter_code = 8'h21;
            8'h64: letter_code = 8'h23; 8'h65: letter_code = 8'h24; 8'h66: letter_code = 8'h2B;
            8'h67: letter_code = 8'h34; 8'h68: letter_code = 8'h33; 8'h69: letter_code = 8'h43;
            8'h6A: letter_code = 8'h3B; 8'h6B: letter_code = 8'h42; 8'h6C: letter_code = 8'h4B;
            8'h6D: letter_code = 8'h3A; 8'h6E: letter_code = 8'h31; 8'h6F: letter_code = 8'h44;
            8'h70: letter_code = 8'h4D; 8'h71: letter_code = 8'h15; 8'h72: letter_code = 8'h2D;
            8'h73: letter_code = 8'h1B; 8'h74: letter_code = 8'h2C; 8'h75: letter_code = 8'h3C;
            8'h76: letter_code = 8'h2A; 8'h77: letter_code = 8'h1D; 8'h78: letter_code = 8'h22;
            8'h79: letter_code = 8'h35; 8'h7A: letter_code = 8'h1A;
            default: letter_code = 8'h00;
        endcase
    endfunction

    always_comb begin
        code      = 8'h00;
        shift_req = 1'b0;
        ext_req   = 1'b0;
        hit       = 1'b1;
        if (ascii >= 8'h61 && ascii <= 8'h7A) begin
            code = letter_code(ascii);
        end else if (ascii >= 8'h41 && ascii <= 8'h5A) begin
            // Upper case shares the key of its lower-case letter.
            code      = letter_code(ascii | 8'h20);
            shift_req = 1'b1;
        end else begin
            case (ascii)
                8'h30: code = 8'h45; 8'h31: code = 8'h16; 8'h32: code = 8'h1E; 8'h33: code = 8'h26;
                8'h34: code = 8'h25; 8'h35: code = 8'h2E; 8'h36: code = 8'h36; 8'h37: code = 8'h3D;
                8'h38: code = 8'h3E; 8'h39: code = 8'h46;
                8'h29: {shift_req, code} = {1'b1, 8'h45}; 8'h21: {shift_req, code} = {1'b1, 8'h16};
                8'h40: {shift_req, code} = {1'b1, 8'h1E}; 8'h23: {shift_req, code} = {1'b1, 8'h26};
                8'h24: {shift_req, code} = {1'b1, 8'h25}; 8'h25: {shift_req, code} = {1'b1, 8'h2E};
                8'h5E: {shift_req, code} = {1'b1, 8'h36}; 8'h26: {shift_req, code} = {1'b1, 8'h3D};
                8'h2A: {shift_req, code} = {1'b1, 8'h3E}; 8'h28: {shift_req, code} = {1'b1, 8'h46};
                8'h7E: {shift_req, code} = {1'b1, 8'h0E}; 8'h5F: {shift_req, code} = {1'b1, 8'h4E};
                8'h2B: {shift_req, code} = {1'b1, 8'h55}; 8'h7C: {shift_req, code} = {1'b1, 8'h5D};
                8'h3A: {shift_req, code} = {1'b1, 8'h4C}; 8'h22: {shift_req, code} = {1'b1, 8'h52};
                8'h7B: {shift_req, code} = {1'b1, 8'h54}; 8'h7D: {shift_req, code} = {1'b1, 8'h5B};
                8'h3C: {shift_req, code} = {1'b1, 8'h41}; 8'h3E: {shift_req, code} = {1'b1, 8'h49};
                8'h3F: {shift_req, code} = {1'b1, 8'h4A};
                8'h60: code = 8'h0E; 8'h2D: code = 8'h4E; 8'h3D: code = 8'h55; 8'h5C: code = 8'h5D;
                8'h3B: code = 8'h4C; 8'h27: code = 8'h52; 8'h5B: code = 8'h54; 8'h5D: code = 8'h5B;
                8'h2C: code = 8'h41; 8'h2E: code = 8'h49; 8'h2F: code = 8'h4A;
                8'h0A: code = 8'h5A; 8'h08: code = 8'h66; 8'h20: code = 8'h29; 8'h09: code = 8'h0D;
                8'h1B: code = 8'h76;
                8'h80: code = 8'h05; 8'h81: code = 8'h06; 8'h82: code = 8'h04; 8'h83: code = 8'h0C;
                8'h84: code = 8'h03; 8'h85: code = 8'h0B; 8'h86: code = 8'h83; 8'h87: code = 8'h0A;
                8'h88: code = 8'h01; 8'h89: code = 8'h09; 8'h8A: code = 8'h78; 8'h8B: code = 8'h07;
                8'h18: {ext_req, code} = {1'b1, 8'h75}; 8'h19: {ext_req, code} = {1'b1, 8'h72};
                8'h1A: {ext_req, code} = {1'b1, 8'h74}; 8'h7F: {ext_req, code} = {1'b1, 8'h71};
                8'h0B: {ext_req, code} = {1'b1, 8'h70}; 8'h1E: {ext_req, code} = {1'b1, 8'h7D};
                8'h1F: {ext_req, code} = {1'b1, 8'h7A}; 8'h11: {ext_req, code} = {1'b1, 8'h6C};
                8'h10: {ext_req, code} = {1'b1, 8'h69};
                default: hit = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ascii_ps2_seq.sv
// rtl/ascii_ps2_seq.sv - ASCII character to PS/2 Set-2 make/break byte sequencer
//
// Purpose: accepts one character per handshake and emits the full make/break
//          byte sequence for that key, one byte per handshake.
// Ports  : clk, rst_n (async active-low)
//          ascii_valid/ascii_data/ascii_ready  character input handshake
//          ps2_valid/ps2_data/ps2_ready        scan byte output handshake
//          busy      sequence in progress
//          unmapped  one-cycle pulse when an accepted character has no key
// Config : ASCII_PS2_GAP_EN inserts GAP_CYCLES idle cycles between bytes.
module ascii_ps2_seq
    import ps2_codes_pkg::*;
#(
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ascii_valid,
    input  logic [7:0] ascii_data,
    output logic       ascii_ready,
    output logic       ps2_valid,
    output logic [7:0] ps2_data,
    input  logic       ps2_ready,
    output logic       busy,
    output logic       unmapped
);

    state_t     state;
    state_t     adv_state;
    logic [7:0] char_q;
    logic [7:0] lut_in;
    logic [7:0] code;
    logic       shift_req;
    logic       ext_req;
    logic       hit;
    logic       accept;
    logic       byte_done;

`ifdef ASCII_PS2_GAP_EN
    state_t     pend_state;
    logic [7:0] gap_cnt;
`endif

    // In IDLE the table looks at the incoming character so the first byte can
    // be registered on the accept edge; afterwards it looks at the latch.
    assign lut_in    = (state == IDLE) ? ascii_data : char_q;
    assign accept    = ascii_valid && ascii_ready;
    assign byte_done = ps2_valid && ps2_ready;
    assign adv_state = seq_next(state, shift_req, ext_req);

    ascii2ps2_lut u_lut (
        .ascii     (lut_in),
        .code      (code),
        .shift_req (shift_req),
        .ext_req   (ext_req),
        .hit       (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            char_q      <= 8'h00;
            ascii_ready <= 1'b1;
            ps2_valid   <= 1'b0;
            ps2_data    <= 8'h00;
            busy        <= 1'b0;
            unmapped    <= 1'b0;
`ifdef ASCII_PS2_GAP_EN
            pend_state  <= IDLE;
            gap_cnt     <= 8'h00;
`endif
        end else begin
            unmapped <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        char_q <= ascii_data;
                        if (hit) begin
                            state       <= adv_state;
                            ps2_valid   <= 1'b1;
                            ps2_data    <= seq_byte(adv_state, code);
                            busy        <= 1'b1;
                            ascii_ready <= 1'b0;
                        end else begin
                            unmapped <= 1'b1;
                        end
                    end
                end
`ifdef ASCII_PS2_GAP_EN
                GAP: begin
                    if (gap_cnt == 8'd1) begin
                        state     <= pend_state;
                        ps2_valid <= 1'b1;
                        ps2_data  <= seq_byte(pend_state, code);
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
`endif
                default: begin
                    if (byte_done) begin
                        if (adv_state == IDLE) begin
                            state       <= IDLE;
                            ps2_valid   <= 1'b0;
                            ps2_data    <= 8'h00;
                            busy        <= 1'b0;
                            ascii_ready <= 1'b1;
                        end else begin
`ifdef ASCII_PS2_GAP_EN
                            state      <= GAP;
                            pend_state <= adv_state;
                            gap_cnt    <= 8'(GAP_CYCLES);
                            ps2_valid  <= 1'b0;
`else
                            state    <= adv_state;
                            ps2_data <= seq_byte(adv_state, code);
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_ps2_seq.sv
// tb/tb_ascii_ps2_seq.sv - scoreboard testbench for ascii_ps2_seq
module tb_ascii_ps2_seq;

    localparam int TB_GAP = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ascii_valid;
    logic [7:0] ascii_data;
    logic       ascii_ready;
    logic       ps2_valid;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       busy;
    logic       unmapped;

    int tests  = 0;
    int failed = 0;
    int ready_mode = 0;   // 0: always ready, 1: toggle, 2: random
    int sb[$];            // expected bytes; -1 stands for an unmapped pulse

    ascii_ps2_seq #(.GAP_CYCLES(TB_GAP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ascii_valid (ascii_valid),
        .ascii_data  (ascii_data),
        .ascii_ready (ascii_ready),
        .ps2_valid   (ps2_valid),
        .ps2_data    (ps2_data),
        .ps2_ready   (ps2_ready),
        .busy        (busy),
        .unmapped    (unmapped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference key table built from the character classes.
    function automatic void lookup(input logic [7:0] c, output int code, output bit sh, output bit ex);
        string letters = "abcdefghijklmnopqrstuvwxyz";
        string dsh     = ")!@#$%^&*(";
        int sym[11]  = '{'h60,'h2D,'h3D,'h5C,'h3B,'h27,'h5B,'h5D,'h2C,'h2E,'h2F};
        int ssym[11] = '{'h7E,'h5F,'h2B,'h7C,'h3A,'h22,'h7B,'h7D,'h3C,'h3E,'h3F};
        int lcode[26] = '{'h1C,'h32,'h21,'h23,'h24,'h2B,'h34,'h33,'h43,'h3B,'h42,'h4B,'h3A,
                          'h31,'h44,'h4D,'h15,'h2D,'h1B,'h2C,'h3C,'h2A,'h1D,'h22,'h35,'h1A};
        int dcode[10] = '{'h45,'h16,'h1E,'h26,'h25,'h2E,'h36,'h3D,'h3E,'h46};
        int scode[11] = '{'h0E,'h4E,'h55,'h5D,'h4C,'h52,'h54,'h5B,'h41,'h49,'h4A};
        int pk[5]  = '{'h0A,'h08,'h20,'h09,'h1B};
        int pc[5]  = '{'h5A,'h66,'h29,'h0D,'h76};
        int ek[9]  = '{'h18,'h19,'h1A,'h7F,'h0B,'h1E,'h1F,'h11,'h10};
        int ec[9]  = '{'h75,'h72,'h74,'h71,'h70,'h7D,'h7A,'h6C,'h69};
        int fc[12] = '{'h05,'h06,'h04,'h0C,'h03,'h0B,'h83,'h0A,'h01,'h09,'h78,'h07};
        int ci = int'(c);
        code = -1; sh = 0; ex = 0;
        for (int i = 0; i < 26; i++) begin
            if (ci == int'(letters[i])) code = lcode[i];
            if (ci == int'(letters[i]) - 32) begin code = lcode[i]; sh = 1; end
        end
        if (ci >= 'h30 && ci <= 'h39) code = dcode[ci - 'h30];
        for (int i = 0; i < 10; i++)
            if (ci == int'(dsh[i])) begin code = dcode[i]; sh = 1; end
        for (int i = 0; i < 11; i++) begin
            if (ci == sym[i]) code = scode[i];
            if (ci == ssym[i]) begin code = scode[i]; sh = 1; end
        end
        for (int i = 0; i < 5; i++) if (ci == pk[i]) code = pc[i];
        for (int i = 0; i < 9; i++) if (ci == ek[i]) begin code = ec[i]; ex = 1; end
        if (ci >= 'h80 && ci <= 'h8B) code = fc[ci - 'h80];
    endfunction

    task automatic push_expected(input logic [7:0] c);
        int code; bit sh; bit ex;
        lookup(c, code, sh, ex);
        if (code < 0) sb.push_back(-1);
        else if (ex) begin
            sb.push_back('hE0); sb.push_back(code); sb.push_back('hE0);
            sb.push_back('hF0); sb.push_back(code);
        end else if (sh) begin
            sb.push_back('h12); sb.push_back(code); sb.push_back('hF0);
            sb.push_back(code); sb.push_back('hF0); sb.push_back('h12);
        end else begin
            sb.push_back(code); sb.push_back('hF0); sb.push_back(code);
        end
    endtask

    // Returns #1 after the accept edge.
    task automatic send(input logic [7:0] c);
        int n = 0;
        @(posedge clk); #1;
        while (!ascii_ready && n < 1000) begin @(posedge clk); #1; n++; end
        if (!ascii_ready) begin
            tests++; failed++;
            $display("FAIL send_wait: ascii_ready stayed 0, expected 1");
        end else begin
            push_expected(c);
            ascii_valid = 1'b1;
            ascii_data  = c;
            @(posedge clk); #1;
            ascii_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 5000) begin @(posedge clk); #1; n++; end
        check("drain_pending", sb.size() + int'(busy), 0);
    endtask

    // Ready driver
    initial begin
        ps2_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: ps2_ready = 1'b1;
                1: ps2_ready = ~ps2_ready;
                default: ps2_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops and compares on every handshake or unmapped pulse,
    // and checks that a stalled byte is held.
    initial begin
        bit prev_stall = 0;
        logic [7:0] prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", int'(ps2_valid), 1);
                    check("stall_data", int'(ps2_data), int'(prev_data));
                end
                if (unmapped || (ps2_valid && ps2_ready)) begin
                    if (sb.size() == 0) begin
                        tests++; failed++;
                        $display("FAIL sb_empty: got output %0h with nothing expected", ps2_data);
                    end else if (unmapped) begin
                        check("unmapped_pulse", -1, sb.pop_front());
                    end else begin
                        check("ps2_byte", int'(ps2_data), sb.pop_front());
                    end
                end
                prev_stall = ps2_valid && !ps2_ready;
                prev_data  = ps2_data;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        ascii_valid = 1'b0;
        ascii_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ascii_ready", int'(ascii_ready), 1);
        check("rst_ps2_valid", int'(ps2_valid), 0);
        check("rst_ps2_data", int'(ps2_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_unmapped", int'(unmapped), 0);
        rst_n = 1'b1;

        ready_mode = 0;
`ifndef ASCII_PS2_GAP_EN
        send(8'h61);
        check("a_b0_valid", int'(ps2_valid), 1);
        check("a_b0_data", int'(ps2_data), 'h1C);
        check("a_b0_busy", int'(busy), 1);
        @(posedge clk); #1;
        check("a_b1_data", int'(ps2_data), 'hF0);
        check("a_b1_busy", int'(busy), 1);
        @(posedge clk); #1;
        check("a_b2_data", int'(ps2_data), 'h1C);
        check("a_b2_ready", int'(ascii_ready), 0);
        @(posedge clk); #1;
        check("a_end_valid", int'(ps2_valid), 0);
        check("a_end_busy", int'(busy), 0);
        check("a_end_ready", int'(ascii_ready), 1);
        check("a_unmapped", int'(unmapped), 0);
`else
        send(8'h31);
        check("g_b0_data", int'(ps2_data), 'h16);
        check("g_b0_valid", int'(ps2_valid), 1);
        for (int k = 0; k < 2; k++) begin
            for (int g = 0; g < TB_GAP; g++) begin
                @(posedge clk); #1;
                check("g_idle_valid", int'(ps2_valid), 0);
                check("g_idle_busy", int'(busy), 1);
            end
            @(posedge clk); #1;
            check("g_next_valid", int'(ps2_valid), 1);
            check("g_next_data", int'(ps2_data), (k == 0) ? 'hF0 : 'h16);
        end
        @(posedge clk); #1;
        check("g_end_busy", int'(busy), 0);
`endif
        drain();

        ready_mode = 1;
        send(8'h41);
        drain();

        ready_mode = 0;
        send(8'h18);
        for (int k = 0; k < 4; k++) begin
            check("ext_ascii_ready_low", int'(ascii_ready), 0);
            @(posedge clk); #1;
        end
        send(8'h1B);
        drain();

        send(8'hC5);
        check("unm_pulse", int'(unmapped), 1);
        check("unm_ready", int'(ascii_ready), 1);
        check("unm_valid", int'(ps2_valid), 0);
        check("unm_busy", int'(busy), 0);
        @(posedge clk); #1;
        check("unm_pulse_end", int'(unmapped), 0);
        drain();

        send(8'h41);
        @(posedge clk); @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_valid", int'(ps2_valid), 0);
        check("mid_rst_data", int'(ps2_data), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ready", int'(ascii_ready), 1);
        check("mid_rst_unmapped", int'(unmapped), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        send(8'h62);
        drain();

        ready_mode = 2;
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(8'($urandom_range(0, 255)));
        end
        drain();

        check("sb_final_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
